// File: rtl/relay_nibble_tx.sv
// relay_nibble_tx: transmit side of the relay nibble link.
// Accepts 4-bit nibbles over valid/ready. Each nibble is sent on one relay line as a frame:
// START (high,high sync violation), D3..D0 Manchester coded (1 = high,low; 0 = low,high),
// an even-parity bit coded like data, then GUARD_BITS bit periods of low. The line level is
// XORed with the invert value latched at acceptance.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   data_in    nibble to send, sampled on acceptance
//   data_valid source has a nibble on data_in
//   data_ready registered, high only in idle
//   invert     line polarity select (1 = inverted)
//   relay_out  registered serial relay line
//   busy       frame in progress
//   frame_done one-cycle pulse in the last guard cycle
module relay_nibble_tx #(
    parameter int unsigned HALF_BIT   = 16,
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       invert,
    output logic       relay_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int unsigned GW = $clog2(GUARD_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StGuard
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic          half_q, half_d;
    logic [1:0]    bit_idx_q, bit_idx_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
    logic [3:0]    data_q, data_d;
    logic          inv_q, inv_d;
    logic          relay_out_q, relay_out_d;
    logic          data_ready_q, data_ready_d;

    logic accept;
    logic half_wrap;
    logic bit_end;
    logic cur_bit;

    assign accept    = data_valid && data_ready_q;
    assign half_wrap = (half_cnt_q == HW'(HALF_BIT - 1));
    assign bit_end   = half_wrap && half_q;

    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        half_d       = half_q;
        bit_idx_d    = bit_idx_q;
        guard_cnt_d  = guard_cnt_q;
        data_d       = data_q;
        inv_d        = inv_q;
        frame_done   = 1'b0;
        relay_out_d  = 1'b0;
        cur_bit      = 1'b0;

        if (state_q != StIdle) begin
            half_cnt_d = half_wrap ? '0 : half_cnt_q + HW'(1);
            half_d     = half_wrap ? ~half_q : half_q;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d     = data_in;
                    inv_d      = invert;
                    state_d    = StStart;
                    half_cnt_d = '0;
                    half_d     = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 2'd3;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 2'd0) begin
                        state_d = StParity;
                    end else begin
                        bit_idx_d = bit_idx_q - 2'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d     = StGuard;
                    guard_cnt_d = '0;
                end
            end
            StGuard: begin
                if (bit_end) begin
                    if (guard_cnt_q == GW'(GUARD_BITS - 1)) begin
                        state_d    = StIdle;
                        frame_done = 1'b1;
                    end else begin
                        guard_cnt_d = guard_cnt_q + GW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // relay_out is registered, so it is computed from the state of the coming cycle.
        case (state_d)
            StIdle:   relay_out_d = invert;
            StStart:  relay_out_d = 1'b1 ^ inv_d;
            StData: begin
                cur_bit     = data_d[bit_idx_d];
                relay_out_d = (half_d ? ~cur_bit : cur_bit) ^ inv_d;
            end
            StParity: begin
                cur_bit     = ^data_d;
                relay_out_d = (half_d ? ~cur_bit : cur_bit) ^ inv_d;
            end
            StGuard:  relay_out_d = inv_d;
            default:  relay_out_d = 1'b0;
        endcase

        data_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            half_cnt_q   <= '0;
            half_q       <= 1'b0;
            bit_idx_q    <= 2'd0;
            guard_cnt_q  <= '0;
            data_q       <= 4'd0;
            inv_q        <= 1'b0;
            relay_out_q  <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            half_q       <= half_d;
            bit_idx_q    <= bit_idx_d;
            guard_cnt_q  <= guard_cnt_d;
            data_q       <= data_d;
            inv_q        <= inv_d;
            relay_out_q  <= relay_out_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign relay_out  = relay_out_q;
    assign data_ready = data_ready_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/relay_nibble_tx.md
Name: relay_nibble_tx

Overview:
- Transmit side of the relay nibble link. Accepts 4-bit command/data nibbles over a valid/ready handshake.
- Serializes each nibble as a framed, Manchester-coded bit stream on a single relay line toward the remote board's relay decoder.
- Sits between the local mode/control logic (source of nibbles) and the relay output pin.
- Optionally inverts line polarity for fake-reader operation.

Parameters:
- HALF_BIT, 16, clocks per half bit period; bit period = 2*HALF_BIT; must be >= 2.
- GUARD_BITS, 2, bit periods of forced idle after each frame; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  4  nibble to send; sampled only on acceptance
- data_valid  input  1  source has a nibble on data_in
- data_ready  output  1  block can accept a nibble this cycle
- invert  input  1  1 = invert relay line polarity (fake-reader side)
- relay_out  output  1  registered serial relay line
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse in the last guard cycle of a frame

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; relay_out=0; data_ready=0; busy=0; frame_done=0; counters=0.
  - data_ready rises on the first clk edge after reset deasserts.
- Frame format, per-bit level pattern, first half then second half:
  - START: high, high. This is a Manchester violation and is the sync marker.
  - D3, D2, D1, D0 (MSB first): 1 is sent as high, low; 0 is sent as low, high.
  - PARITY: P = D3^D2^D1^D0, so the data bits plus P have even parity. Coded like a data bit.
  - GUARD: low for GUARD_BITS*2*HALF_BIT cycles.
- Handshake:
  - Acceptance occurs when data_valid && data_ready at a clk edge.
  - On acceptance: data_in is latched, invert is latched, data_ready drops, and state goes to START.
  - data_valid while not ready is ignored; no queueing.
  - data_ready = 1 only in IDLE, registered.
- Timing (defaults): acceptance edge at cycle T.
  - relay_out shows the START level in cycles T+1..T+32.
  - D3 occupies T+33..T+64, D2 T+65..T+96, D1 T+97..T+128, D0 T+129..T+160.
  - PARITY occupies T+161..T+192; GUARD occupies T+193..T+256.
  - frame_done pulses in cycle T+256; data_ready=1 from cycle T+257.
  - Frame length = (6+GUARD_BITS)*2*HALF_BIT cycles.
  - Back-to-back: with data_valid held high, the next acceptance is at the edge ending cycle T+257, and the next START begins at T+258.
- State machine: IDLE -> START -> DATA (bit index 3 down to 0) -> PARITY -> GUARD -> IDLE.
  - Half-bit counter counts 0..HALF_BIT-1; a half flag toggles on each wrap.
  - A bit ends at the wrap with half=1.
  - Bit index decrements at the end of each DATA bit.
  - DATA exits after index 0.
  - GUARD uses a separate guard bit counter of width clog2(GUARD_BITS+1).
- Polarity:
  - relay_out = coded_level XOR invert_latched during a frame.
  - In IDLE, relay_out = live invert, registered, so the idle level follows invert one cycle later.
  - A change on invert mid-frame has no effect until IDLE.
- busy = 1 from T+1 through T+256 inclusive.
- Reset mid-frame: relay_out=0 immediately (asynchronous); the frame is discarded with no frame_done pulse; the nibble is lost.
- Simultaneous events: acceptance in the same cycle that invert toggles latches the new invert value.

Test Plan:
- Reset then idle, invert=0 -> relay_out=0, busy=0, data_ready=1 from first edge after reset release, frame_done never pulses.
- Send 4'b1010 at T (defaults) -> START high T+1..T+32; D3: high T+33..T+48, low T+49..T+64; D2: low, high; D1: high, low; D0: low, high; P=0: low T+161..T+176, high T+177..T+192; low T+193..T+256; frame_done only at T+256.
- Send 4'b0111 with invert=1 -> P=1; the whole waveform is the bitwise complement of the non-inverted case; idle level 1 before and after the frame.
- data_valid held high with nibbles 4'h3 then 4'hC -> exactly two frames; second START begins at T+258; data_ready low T+1..T+256; each nibble accepted once.
- Assert reset at T+100 during D1 -> relay_out=0 in the same cycle, no frame_done; after release, a new nibble 4'hF is framed correctly with P=0.
- HALF_BIT=2, GUARD_BITS=1, send 4'h0 -> frame length 28 cycles; bit pattern START hh, four 0 bits lh, P=0 lh, guard ll; frame_done at T+28.
